// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic cells.
package arith_pkg;

    localparam int unsigned W_MIN = 2;
    localparam int unsigned W_MAX = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder built from two half-adder stages.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic hs1, hc1, hc2;

    assign hs1  = a ^ b;
    assign hc1  = a & b;
    assign s    = hs1 ^ cin;
    assign hc2  = hs1 & cin;
    assign cout = hc1 | hc2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: one full-adder cell and a carry flop, LSB first,
// result with carry-out and signed overflow presented alongside a done pulse.
module serial_adder
    import arith_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int unsigned CW = $clog2(W);
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    if (W < W_MIN || W > W_MAX) begin : g_bad_width
        $error("serial_adder: W outside supported range");
    end

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   r_q, r_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           c_q, c_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;
    logic           ovf_q, ovf_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           fa_s, fa_c;

    full_adder u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (c_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    r_d     = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Sum bits enter at the MSB so the first bit lands at bit 0 after W shifts.
                a_d   = {1'b0, a_q[W-1:1]};
                b_d   = {1'b0, b_q[W-1:1]};
                r_d   = {fa_s, r_q[W-1:1]};
                c_d   = fa_c;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = {fa_s, r_q[W-1:1]};
                    cout_d  = fa_c;
                    ovf_d   = c_q ^ fa_c;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
